// File: rtl/ysyx_22041412_csr_trap.sv
// ---------------------------------------------------------------------------
// ysyx_22041412_csr_trap
//
// Machine-mode CSR file and trap sequencer for a single-issue RISC-V core.
// It holds mstatus/mie/mtvec/mscratch/mepc/mcause/mip/mcycle and executes
// CSR instructions in two cycles. It also takes ecall exceptions and the
// M-mode interrupts (MEI/MSI/MTI), handles mret, and asks the core to jump
// through a redirect handshake.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   csr_valid/ready     CSR instruction request / one-cycle completion pulse
//   csr_op, csr_addr    func3 and 12-bit CSR address of the request
//   csr_wdata           rs1 value or zero-extended uimm
//   csr_rdata           old CSR value, valid with csr_ready
//   csr_illegal         unimplemented CSR address, valid with csr_ready
//   ecall_i, mret_i     one-cycle pulses from the decoder
//   pc_i                PC saved to mepc on a trap
//   irq_msip/mtip/meip  level interrupt lines (software/timer/external)
//   redirect_valid/pc   jump request to the core (trap handler or mepc)
//   redirect_ack        core accepted the redirect
//   irq_pending         enabled interrupt pending while mstatus.MIE=1
// ---------------------------------------------------------------------------
module ysyx_22041412_csr_trap #(
    parameter int              XLEN        = 64,
    parameter bit              VEC_EN      = 1'b1,
    parameter logic [XLEN-1:0] RST_MSTATUS = 'h1800
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    output logic            csr_ready,
    input  logic [2:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            ecall_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            irq_msip,
    input  logic            irq_mtip,
    input  logic            irq_meip,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ack,
    output logic            irq_pending
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CSR_WB = 2'd1;
    localparam logic [1:0] TRAP   = 2'd2;
    localparam logic [1:0] REDIR  = 2'd3;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;

    // Bits of mstatus that never change: everything except MIE/MPIE, with
    // MPP hard-wired to machine mode.
    localparam logic [XLEN-1:0] MSTATUS_FIXED =
        (RST_MSTATUS & ~XLEN'(32'h88)) | XLEN'(32'h1800);

    localparam logic [XLEN-1:0] LOW2_MASK = ~XLEN'(3);

    logic [1:0]      state;
    logic [11:0]     addr_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] wdata_q;

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mcycle_q;

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] mip_val;
    logic [XLEN-1:0] irq_enabled;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] csr_old;
    logic [XLEN-1:0] csr_new;
    logic            csr_hit;
    logic            csr_we;
    logic [XLEN-1:0] trap_target;

    // Architectural views of mstatus and mip; mip mirrors the live lines.
    always_comb begin
        mstatus_val     = MSTATUS_FIXED;
        mstatus_val[3]  = mstatus_mie;
        mstatus_val[7]  = mstatus_mpie;
        mip_val         = '0;
        mip_val[3]      = irq_msip;
        mip_val[7]      = irq_mtip;
        mip_val[11]     = irq_meip;
    end

    // Pending-interrupt detection and cause selection, MEI > MSI > MTI.
    always_comb begin
        irq_enabled = mie_q & mip_val;
        irq_pending = mstatus_mie & (irq_enabled[3] | irq_enabled[7] | irq_enabled[11]);
        if (irq_enabled[11]) begin
            irq_code = 4'd11;
        end else if (irq_enabled[3]) begin
            irq_code = 4'd3;
        end else begin
            irq_code = 4'd7;
        end
    end

    // Read mux for the latched CSR address plus the op-dependent new value.
    // Set/clear with a zero operand is a pure read and must not write.
    always_comb begin
        csr_hit = 1'b1;
        case (addr_q)
            ADDR_MSTATUS:  csr_old = mstatus_val;
            ADDR_MIE:      csr_old = mie_q;
            ADDR_MTVEC:    csr_old = mtvec_q;
            ADDR_MSCRATCH: csr_old = mscratch_q;
            ADDR_MEPC:     csr_old = mepc_q;
            ADDR_MCAUSE:   csr_old = mcause_q;
            ADDR_MIP:      csr_old = mip_val;
            ADDR_MCYCLE:   csr_old = mcycle_q;
            default: begin
                csr_old = '0;
                csr_hit = 1'b0;
            end
        endcase
        case (op_q[1:0])
            2'b01:   csr_new = wdata_q;
            2'b10:   csr_new = csr_old | wdata_q;
            2'b11:   csr_new = csr_old & ~wdata_q;
            default: csr_new = csr_old;
        endcase
        csr_we = csr_hit && (op_q[1:0] != 2'b00) && !(op_q[1] && (wdata_q == '0));
    end

    // Handler address: vectored mode offsets interrupts by 4*cause,
    // exceptions always land on the base.
    always_comb begin
        trap_target = mtvec_q & LOW2_MASK;
        if (VEC_EN && mtvec_q[0] && mcause_q[XLEN-1]) begin
            trap_target = (mtvec_q & LOW2_MASK) +
                          {{(XLEN-7){1'b0}}, mcause_q[4:0], 2'b00};
        end
    end

    // Main sequencer. New requests are only looked at in IDLE, in the order
    // ecall > mret > CSR access > interrupt. mcycle counts every cycle unless
    // a CSR write to it lands in the same cycle, which wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            addr_q         <= '0;
            op_q           <= '0;
            wdata_q        <= '0;
            mstatus_mie    <= RST_MSTATUS[3];
            mstatus_mpie   <= RST_MSTATUS[7];
            mie_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mcycle_q       <= '0;
            csr_ready      <= 1'b0;
            csr_illegal    <= 1'b0;
            csr_rdata      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            csr_ready   <= 1'b0;
            csr_illegal <= 1'b0;
            mcycle_q    <= mcycle_q + XLEN'(1);
            case (state)
                IDLE: begin
                    if (ecall_i) begin
                        mepc_q       <= pc_i & LOW2_MASK;
                        mcause_q     <= XLEN'(11);
                        mstatus_mpie <= mstatus_mie;
                        mstatus_mie  <= 1'b0;
                        state        <= TRAP;
                    end else if (mret_i) begin
                        mstatus_mie    <= mstatus_mpie;
                        mstatus_mpie   <= 1'b1;
                        redirect_pc    <= mepc_q;
                        redirect_valid <= 1'b1;
                        state          <= REDIR;
                    end else if (csr_valid) begin
                        addr_q  <= csr_addr;
                        op_q    <= csr_op;
                        wdata_q <= csr_wdata;
                        state   <= CSR_WB;
                    end else if (irq_pending) begin
                        mepc_q       <= pc_i & LOW2_MASK;
                        mcause_q     <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
                        mstatus_mpie <= mstatus_mie;
                        mstatus_mie  <= 1'b0;
                        state        <= TRAP;
                    end
                end
                CSR_WB: begin
                    csr_ready   <= 1'b1;
                    csr_rdata   <= csr_old;
                    csr_illegal <= !csr_hit;
                    if (csr_we) begin
                        case (addr_q)
                            ADDR_MSTATUS: begin
                                mstatus_mie  <= csr_new[3];
                                mstatus_mpie <= csr_new[7];
                            end
                            ADDR_MIE:      mie_q      <= csr_new;
                            ADDR_MTVEC:    mtvec_q    <= (csr_new & LOW2_MASK) |
                                                         XLEN'(VEC_EN && csr_new[0]);
                            ADDR_MSCRATCH: mscratch_q <= csr_new;
                            ADDR_MEPC:     mepc_q     <= csr_new & LOW2_MASK;
                            ADDR_MCAUSE:   mcause_q   <= csr_new;
                            ADDR_MCYCLE:   mcycle_q   <= csr_new;
                            default: ;
                        endcase
                    end
                    state <= IDLE;
                end
                TRAP: begin
                    redirect_pc    <= trap_target;
                    redirect_valid <= 1'b1;
                    state          <= REDIR;
                end
                REDIR: begin
                    if (redirect_ack) begin
                        redirect_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_csr_trap.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041412_csr_trap
//
// Self-checking bench for ysyx_22041412_csr_trap (XLEN=64, vectored mode on).
// A table of CSR accesses with hand-derived results, a randomized CSR
// sequence checked against a register-level reference model, and hand-written
// trap / mret / interrupt / reset sequences.
// ---------------------------------------------------------------------------
module tb_ysyx_22041412_csr_trap;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            csr_valid;
    logic            csr_ready;
    logic [2:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            ecall_i;
    logic            mret_i;
    logic [XLEN-1:0] pc_i;
    logic            irq_msip;
    logic            irq_mtip;
    logic            irq_meip;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ack;
    logic            irq_pending;

    ysyx_22041412_csr_trap #(.XLEN(XLEN), .VEC_EN(1'b1), .RST_MSTATUS(64'h1800)) dut (
        .clk(clk), .rst(rst),
        .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_op(csr_op),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal), .ecall_i(ecall_i), .mret_i(mret_i), .pc_i(pc_i),
        .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ack(redirect_ack), .irq_pending(irq_pending)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [2:0]  op;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_illegal;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   vec_count  = 0;
    int   miscompares = 0;

    // Reference model state: the architectural CSR contents as seen by software.
    logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;

    // Safety net so the run always ends even if the design wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        csr_valid = 1'b0; csr_op = '0; csr_addr = '0; csr_wdata = '0;
        ecall_i = 1'b0; mret_i = 1'b0; pc_i = '0;
        irq_msip = 1'b0; irq_mtip = 1'b0; irq_meip = 1'b0; redirect_ack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Issue one CSR request from IDLE and wait (bounded) for csr_ready.
    task automatic applyStimulus(input logic [11:0] addr, input logic [2:0] op,
                                 input logic [63:0] wdata, output logic [63:0] rdata,
                                 output logic illegal, output int lat);
        csr_valid = 1'b1; csr_addr = addr; csr_op = op; csr_wdata = wdata;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!csr_ready && lat < 40);
        csr_valid = 1'b0;
        rdata   = csr_rdata;
        illegal = csr_illegal;
        checkOutput("csr_ready_seen", 64'(csr_ready), 64'd1);
    endtask

    task automatic csr_check(input string name, input logic [11:0] addr, input logic [2:0] op,
                             input logic [63:0] wdata, input logic [63:0] exp_rdata,
                             input logic exp_illegal);
        logic [63:0] rd;
        logic        ill;
        int          lat;
        applyStimulus(addr, op, wdata, rd, ill, lat);
        checkOutput({name, "_rdata"}, rd, exp_rdata);
        checkOutput({name, "_illegal"}, 64'(ill), 64'(exp_illegal));
        checkOutput({name, "_latency"}, 64'(lat), 64'd2);
    endtask

    // Called one cycle after the triggering event was sampled. Waits for the
    // redirect, holds it for 'stall' cycles checking it stays put, then acks.
    task automatic wait_redirect(input string name, input logic [63:0] exp_pc,
                                 input int exp_lat, input int stall);
        int lat = 1;
        while (!redirect_valid && lat < 10) begin
            tick();
            lat++;
        end
        checkOutput({name, "_redir_valid"}, 64'(redirect_valid), 64'd1);
        checkOutput({name, "_redir_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({name, "_redir_pc"}, redirect_pc, exp_pc);
        for (int i = 0; i < stall; i++) begin
            tick();
            checkOutput({name, "_redir_hold_valid"}, 64'(redirect_valid), 64'd1);
            checkOutput({name, "_redir_hold_pc"}, redirect_pc, exp_pc);
        end
        redirect_ack = 1'b1;
        tick();
        redirect_ack = 1'b0;
        checkOutput({name, "_redir_drop"}, 64'(redirect_valid), 64'd0);
    endtask

    task automatic add_vec(input logic [11:0] addr, input logic [2:0] op, input logic [63:0] wdata,
                           input logic [63:0] exp_rdata, input logic exp_illegal, input string name);
        vec_t v;
        v.addr = addr; v.op = op; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_illegal = exp_illegal; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        m_mstatus = 64'h1800; m_mie = '0; m_mtvec = '0;
        m_mscratch = '0; m_mepc = '0; m_mcause = '0;
    endtask

    // Software-visible behaviour of one CSR instruction (interrupt lines low).
    task automatic model_access(input logic [11:0] addr, input logic [2:0] op,
                                input logic [63:0] wdata, output logic [63:0] exp_r,
                                output logic exp_ill);
        logic [63:0] old_v, new_v;
        bit          writes;
        exp_ill = 1'b0;
        case (addr)
            12'h300: old_v = m_mstatus;
            12'h304: old_v = m_mie;
            12'h305: old_v = m_mtvec;
            12'h340: old_v = m_mscratch;
            12'h341: old_v = m_mepc;
            12'h342: old_v = m_mcause;
            12'h344: old_v = 64'h0;
            default: begin old_v = 64'h0; exp_ill = 1'b1; end
        endcase
        if (op == 3'd1 || op == 3'd5)      new_v = wdata;
        else if (op == 3'd2 || op == 3'd6) new_v = old_v | wdata;
        else if (op == 3'd3 || op == 3'd7) new_v = old_v & ~wdata;
        else                               new_v = old_v;
        writes = !exp_ill && ((op == 3'd1) || (op == 3'd5) ||
                 ((op inside {3'd2, 3'd3, 3'd6, 3'd7}) && wdata != 64'h0));
        if (writes) begin
            case (addr)
                12'h300: m_mstatus  = 64'h1800 | (new_v & 64'h88);
                12'h304: m_mie      = new_v;
                12'h305: m_mtvec    = {new_v[63:2], 1'b0, new_v[0]};
                12'h340: m_mscratch = new_v;
                12'h341: m_mepc     = {new_v[63:2], 2'b00};
                12'h342: m_mcause   = new_v;
                default: ;
            endcase
        end
        exp_r = old_v;
    endtask

    initial begin
        logic [63:0] rd;
        logic        ill;
        int          lat;

        // ---------------- reset state ----------------
        do_reset();
        checkOutput("rst_csr_ready", 64'(csr_ready), 64'd0);
        checkOutput("rst_csr_illegal", 64'(csr_illegal), 64'd0);
        checkOutput("rst_csr_rdata", csr_rdata, 64'd0);
        checkOutput("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        checkOutput("rst_redirect_pc", redirect_pc, 64'd0);
        checkOutput("rst_irq_pending", 64'(irq_pending), 64'd0);
        csr_check("rst_mcycle", 12'hB00, 3'b010, 64'h0, 64'd1, 1'b0);

        // ---------------- table-driven CSR accesses ----------------
        add_vec(12'h305, 3'b001, 64'h8000_0100, 64'h0, 1'b0, "mtvec_w");
        add_vec(12'h305, 3'b010, 64'h0, 64'h8000_0100, 1'b0, "mtvec_s0");
        add_vec(12'h305, 3'b011, 64'h0, 64'h8000_0100, 1'b0, "mtvec_c0");
        add_vec(12'h305, 3'b010, 64'h1, 64'h8000_0100, 1'b0, "mtvec_s1");
        add_vec(12'h305, 3'b010, 64'h0, 64'h8000_0101, 1'b0, "mtvec_rd");
        add_vec(12'h305, 3'b101, 64'h3, 64'h8000_0101, 1'b0, "mtvec_wi");
        add_vec(12'h305, 3'b110, 64'h0, 64'h1, 1'b0, "mtvec_mode");
        add_vec(12'h300, 3'b010, 64'h0, 64'h1800, 1'b0, "mstatus_rd");
        add_vec(12'h300, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1800, 1'b0, "mstatus_w");
        add_vec(12'h300, 3'b111, 64'h8, 64'h1888, 1'b0, "mstatus_ci");
        add_vec(12'h300, 3'b010, 64'h0, 64'h1880, 1'b0, "mstatus_rd2");
        add_vec(12'h340, 3'b001, 64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0, "mscratch_w");
        add_vec(12'h340, 3'b011, 64'hF, 64'hDEAD_BEEF_0123_4567, 1'b0, "mscratch_c");
        add_vec(12'h340, 3'b110, 64'h8, 64'hDEAD_BEEF_0123_4560, 1'b0, "mscratch_si");
        add_vec(12'h340, 3'b000, 64'hFFFF, 64'hDEAD_BEEF_0123_4568, 1'b0, "mscratch_op0");
        add_vec(12'h340, 3'b100, 64'hFFFF, 64'hDEAD_BEEF_0123_4568, 1'b0, "mscratch_op4");
        add_vec(12'h340, 3'b010, 64'h0, 64'hDEAD_BEEF_0123_4568, 1'b0, "mscratch_rd");
        add_vec(12'h341, 3'b001, 64'h8000_0047, 64'h0, 1'b0, "mepc_w");
        add_vec(12'h341, 3'b010, 64'h0, 64'h8000_0044, 1'b0, "mepc_rd");
        add_vec(12'h344, 3'b001, 64'h888, 64'h0, 1'b0, "mip_w");
        add_vec(12'h344, 3'b010, 64'h0, 64'h0, 1'b0, "mip_rd");
        add_vec(12'h342, 3'b001, 64'h5, 64'h0, 1'b0, "mcause_w");
        add_vec(12'h342, 3'b010, 64'h0, 64'h5, 1'b0, "mcause_rd");
        add_vec(12'hFFF, 3'b001, 64'h5, 64'h0, 1'b1, "illegal_fff");
        add_vec(12'h301, 3'b010, 64'h10, 64'h0, 1'b1, "illegal_301");
        add_vec(12'h304, 3'b001, 64'h888, 64'h0, 1'b0, "mie_w");
        add_vec(12'h304, 3'b010, 64'h0, 64'h888, 1'b0, "mie_rd");
        foreach (vecs[i]) begin
            csr_check(vecs[i].name, vecs[i].addr, vecs[i].op, vecs[i].wdata,
                      vecs[i].exp_rdata, vecs[i].exp_illegal);
        end
        checkOutput("tbl_irq_pending", 64'(irq_pending), 64'd0);

        // ---------------- mcycle wrap and increment ----------------
        applyStimulus(12'hB00, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, rd, ill, lat);
        csr_check("mcycle_wrap", 12'hB00, 3'b010, 64'h0, 64'h0, 1'b0);
        csr_check("mcycle_inc", 12'hB00, 3'b010, 64'h0, 64'h2, 1'b0);

        // ---------------- randomized CSR traffic vs model ----------------
        do_reset();
        model_reset();
        for (int n = 0; n < 200; n++) begin
            logic [11:0] addr;
            logic [2:0]  op;
            logic [63:0] wd, er;
            logic        eill;
            case ($urandom_range(0, 11))
                0, 1:    addr = 12'h300;
                2:       addr = 12'h304;
                3, 4:    addr = 12'h305;
                5:       addr = 12'h340;
                6:       addr = 12'h341;
                7:       addr = 12'h342;
                8:       addr = 12'h344;
                9:       addr = 12'h301;
                10:      addr = 12'hF14;
                default: addr = 12'hFFF;
            endcase
            op = 3'($urandom_range(0, 7));
            wd = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) wd = 64'h0;
            model_access(addr, op, wd, er, eill);
            csr_check("rand", addr, op, wd, er, eill);
        end

        // ---------------- ecall trap ----------------
        do_reset();
        csr_check("t_mtvec_w", 12'h305, 3'b001, 64'h8000_0101, 64'h0, 1'b0);
        csr_check("t_mie_on", 12'h300, 3'b010, 64'h8, 64'h1800, 1'b0);
        ecall_i = 1'b1; pc_i = 64'h8000_0040;
        tick();
        ecall_i = 1'b0;
        wait_redirect("ecall", 64'h8000_0100, 2, 0);
        csr_check("ecall_mepc", 12'h341, 3'b010, 64'h0, 64'h8000_0040, 1'b0);
        csr_check("ecall_mcause", 12'h342, 3'b010, 64'h0, 64'd11, 1'b0);
        csr_check("ecall_mstatus", 12'h300, 3'b010, 64'h0, 64'h1880, 1'b0);

        // ---------------- mret with stalled ack ----------------
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        wait_redirect("mret", 64'h8000_0040, 1, 3);
        csr_check("mret_mstatus", 12'h300, 3'b010, 64'h0, 64'h1888, 1'b0);

        // ---------------- vectored interrupts ----------------
        csr_check("irq_mie_w", 12'h304, 3'b001, 64'h888, 64'h0, 1'b0);
        checkOutput("irq_idle_pending", 64'(irq_pending), 64'd0);
        irq_mtip = 1'b1; irq_meip = 1'b1; pc_i = 64'h8000_0200;
        #1;
        checkOutput("irq_pending_high", 64'(irq_pending), 64'd1);
        tick();
        irq_mtip = 1'b0; irq_meip = 1'b0;
        wait_redirect("irq_mei", 64'h8000_012C, 2, 0);
        checkOutput("irq_pending_masked", 64'(irq_pending), 64'd0);
        csr_check("irq_mcause", 12'h342, 3'b010, 64'h0, 64'h8000_0000_0000_000B, 1'b0);
        csr_check("irq_mepc", 12'h341, 3'b010, 64'h0, 64'h8000_0200, 1'b0);
        csr_check("irq_mstatus", 12'h300, 3'b010, 64'h0, 64'h1880, 1'b0);
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        wait_redirect("irq_mret", 64'h8000_0200, 1, 0);
        irq_msip = 1'b1; irq_mtip = 1'b1; pc_i = 64'h8000_0208;
        tick();
        irq_msip = 1'b0; irq_mtip = 1'b0;
        wait_redirect("irq_msi", 64'h8000_010C, 2, 0);
        csr_check("msi_mcause", 12'h342, 3'b010, 64'h0, 64'h8000_0000_0000_0003, 1'b0);

        // ---------------- ecall and CSR request together ----------------
        csr_check("both_scratch_w", 12'h340, 3'b001, 64'h55, 64'h0, 1'b0);
        ecall_i = 1'b1; pc_i = 64'h8000_0300;
        csr_valid = 1'b1; csr_addr = 12'h340; csr_op = 3'b010; csr_wdata = 64'h0;
        tick();
        ecall_i = 1'b0;
        checkOutput("both_no_ready", 64'(csr_ready), 64'd0);
        wait_redirect("both_ecall", 64'h8000_0100, 2, 1);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!csr_ready && lat < 20);
        csr_valid = 1'b0;
        checkOutput("both_csr_ready", 64'(csr_ready), 64'd1);
        checkOutput("both_csr_latency", 64'(lat), 64'd2);
        checkOutput("both_csr_rdata", csr_rdata, 64'h55);
        csr_check("both_mepc", 12'h341, 3'b010, 64'h0, 64'h8000_0300, 1'b0);

        // ---------------- reset during REDIR ----------------
        ecall_i = 1'b1; pc_i = 64'h8000_0400;
        tick();
        ecall_i = 1'b0;
        tick();
        checkOutput("rstredir_valid_before", 64'(redirect_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstredir_valid_after", 64'(redirect_valid), 64'd0);
        checkOutput("rstredir_pc_after", redirect_pc, 64'd0);
        csr_check("rstredir_mcycle", 12'hB00, 3'b010, 64'h0, 64'd1, 1'b0);
        csr_check("rstredir_mtvec", 12'h305, 3'b010, 64'h0, 64'h0, 1'b0);
        csr_check("rstredir_mstatus", 12'h300, 3'b010, 64'h0, 64'h1800, 1'b0);
        csr_check("rstredir_mepc", 12'h341, 3'b010, 64'h0, 64'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
